// File: rtl/bus_pkg.sv
// Shared types and default widths for the Wishbone-classic bus manager.
package bus_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2,
    DONE      = 2'd3
  } bus_state_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts cycles spent waiting for a Wishbone ack; expired flags the last allowed cycle.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  // Holds at the terminal value; the owner leaves the wait state on expiry anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_manager.sv
// Single-outstanding Wishbone-classic master fed by memcontrol read/write requests.
// Optional ack timeout is compiled in with `define BUS_TIMEOUT_EN.
module bus_manager
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_req,
  input  logic                write_req,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] sel,
  output logic                busy,
  output logic [DATA_W-1:0]   rdata,
  output logic                done,
  output logic                rdata_valid,
  output logic                err,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [DATA_W-1:0]   dat_o,
  output logic [DATA_W/8-1:0] sel_o,
  input  logic                ack_i,
  input  logic [DATA_W-1:0]   dat_i,
  output bus_state_t          state
);

  // Handshake: a request is taken only at a rising edge where state is IDLE
  // (busy=0); the requester holds read_req/write_req until it sees busy=0 at
  // such an edge. On the bus side cyc_o/stb_o stay high and every other bus
  // output stays stable until an edge samples ack_i=1 (or the timeout fires).

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic timed_out;

`ifdef BUS_TIMEOUT_EN
  logic in_wait;

  assign in_wait = (state == BUS_READ) || (state == BUS_WRITE);

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (in_wait && !ack_i),
    .expired(timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rdata       <= '0;
      done        <= 1'b0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
      sel_o       <= '0;
    end else begin
      done        <= 1'b0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          // Read wins over a simultaneous write, matching memcontrol.
          if (read_req) begin
            adr_o <= addr;
            sel_o <= sel;
            we_o  <= 1'b0;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            state <= BUS_READ;
          end else if (write_req) begin
            adr_o <= addr;
            dat_o <= wdata;
            sel_o <= sel;
            we_o  <= 1'b1;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            state <= BUS_WRITE;
          end
        end
        BUS_READ: begin
          if (ack_i) begin
            rdata       <= dat_i;
            rdata_valid <= 1'b1;
            done        <= 1'b1;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            state       <= DONE;
          end else if (timed_out) begin
            err   <= 1'b1;
            done  <= 1'b1;
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            state <= DONE;
          end
        end
        BUS_WRITE: begin
          if (ack_i || timed_out) begin
            err   <= !ack_i;
            done  <= 1'b1;
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_manager.sv
// Randomized self-checking bench for bus_manager against a transaction-level model.
module tb_bus_manager;
  import bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk;
  logic          rst;
  logic          read_req;
  logic          write_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] sel;
  logic          busy;
  logic [DW-1:0] rdata;
  logic          done;
  logic          rdata_valid;
  logic          err;
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [SW-1:0] sel_o;
  logic          ack_i;
  logic [DW-1:0] dat_i;
  bus_state_t    state;

  bus_manager #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read_req   (read_req),
    .write_req  (write_req),
    .addr       (addr),
    .wdata      (wdata),
    .sel        (sel),
    .busy       (busy),
    .rdata      (rdata),
    .done       (done),
    .rdata_valid(rdata_valid),
    .err        (err),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .sel_o      (sel_o),
    .ack_i      (ack_i),
    .dat_i      (dat_i),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // scoreboard: read data the model expects, plus the rdata register it tracks
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_rdata;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: one complete transaction, the slave acks after 'waits' extra cycles
  task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [SW-1:0] s,
                         input int waits, input logic [DW-1:0] rsp, input bit noise);
    bit            is_read;
    logic [DW-1:0] exp_rd;
    is_read = rd;
    @(negedge clk);
    read_req  = rd;
    write_req = wr;
    addr      = a;
    wdata     = wd;
    sel       = s;
    if (is_read) exp_q.push_back(rsp);
    @(negedge clk);
    read_req  = 1'b0;
    write_req = 1'b0;
    addr      = $urandom;
    wdata     = $urandom;
    sel       = SW'($urandom);
    check_val("start_busy", busy, 1);
    check_val("start_we", we_o, !is_read);
    check_val("start_adr", adr_o, a);
    check_val("start_sel", sel_o, s);
    if (!is_read) check_val("start_dat", dat_o, wd);
    for (int i = 0; i <= waits; i++) begin
      if (i > 0) @(negedge clk);
      check_val("wait_cyc", cyc_o, 1);
      check_val("wait_stb", stb_o, 1);
      check_val("wait_adr", adr_o, a);
      check_val("wait_done", done, 0);
      if (noise) begin
        write_req = 1'b1;
        read_req  = 1'($urandom_range(0, 1));
      end
      if (i == waits) begin
        ack_i = 1'b1;
        dat_i = rsp;
      end else begin
        ack_i = 1'b0;
        dat_i = $urandom;
      end
    end
    @(negedge clk);
    ack_i     = 1'($urandom_range(0, 1));
    dat_i     = $urandom;
    read_req  = 1'b0;
    write_req = 1'b0;
    exp_rd = is_read ? exp_q.pop_front() : model_rdata;
    model_rdata = exp_rd;
    check_val("done_pulse", done, 1);
    check_val("done_rvalid", rdata_valid, is_read);
    check_val("done_err", err, 0);
    check_val("done_cyc", cyc_o, 0);
    check_val("done_busy", busy, 1);
    check_val("done_rdata", rdata, exp_rd);
    @(negedge clk);
    ack_i = 1'b0;
    check_val("idle_done", done, 0);
    check_val("idle_rvalid", rdata_valid, 0);
    check_val("idle_busy", busy, 0);
    check_val("idle_cyc", cyc_o, 0);
    check_val("idle_rdata", rdata, model_rdata);
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    model_rdata = '0;
    check_val("rst_cyc", cyc_o, 0);
    check_val("rst_stb", stb_o, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_rdata", rdata, model_rdata);
    @(negedge clk);
    ack_i = 1'b0;
    rst   = 1'b1;
  endtask

  initial begin
    bit          rd;
    bit          wr;
    model_rdata = '0;
    rst       = 1'b0;
    read_req  = 1'b1;
    write_req = 1'b0;
    addr      = 32'h0000_0010;
    wdata     = '0;
    sel       = '1;
    ack_i     = 1'b1;
    dat_i     = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check_val("reset_busy", busy, 0);
    check_val("reset_cyc", cyc_o, 0);
    check_val("reset_rdata", rdata, 0);
    check_val("reset_state", DW'(state), 0);
    check_val("reset_done", done, 0);
    check_val("reset_err", err, 0);
    check_val("reset_adr", adr_o, 0);
    read_req = 1'b0;
    ack_i    = 1'b0;
    rst      = 1'b1;
    @(negedge clk);

    run_txn(1, 0, 32'h0000_0040, 32'h0, 4'hF, 2, 32'hCAFE_0001, 0);
    run_txn(0, 1, 32'h0000_0080, 32'h1234_5678, 4'h3, 0, 32'h0, 0);
    run_txn(1, 1, 32'h0000_00C0, 32'hAAAA_5555, 4'h1, 1, 32'h0BAD_F00D, 0);
    run_txn(1, 0, 32'h0000_0100, 32'h0, 4'hC, 3, 32'h7777_1234, 1);

    // reset while a read is on the bus drops cyc_o without waiting for an edge
    @(negedge clk);
    read_req = 1'b1;
    addr     = 32'h0000_0200;
    @(negedge clk);
    read_req = 1'b0;
    check_val("mid_cyc_pre", cyc_o, 1);
    mid_reset();

    run_txn(1, 0, 32'h0000_0300, 32'h0, 4'hF, 0, 32'h5A5A_0F0F, 0);

`ifdef BUS_TIMEOUT_EN
    @(negedge clk);
    read_req = 1'b1;
    addr     = 32'h0000_0400;
    @(negedge clk);
    read_req = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check_val("to_cyc", cyc_o, 1);
      check_val("to_err_early", err, 0);
      @(negedge clk);
    end
    check_val("to_err", err, 1);
    check_val("to_done", done, 1);
    check_val("to_rvalid", rdata_valid, 0);
    check_val("to_cyc_drop", cyc_o, 0);
    check_val("to_rdata", rdata, model_rdata);
    @(negedge clk);
    check_val("to_err_clr", err, 0);
    check_val("to_busy", busy, 0);
`else
    @(negedge clk);
    read_req = 1'b1;
    addr     = 32'h0000_0400;
    @(negedge clk);
    read_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check_val("hang_busy", busy, 1);
      check_val("hang_cyc", cyc_o, 1);
      check_val("hang_err", err, 0);
      @(negedge clk);
    end
    mid_reset();
`endif

    for (int n = 0; n < 30; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(rd, wr, $urandom, $urandom, SW'($urandom), $urandom_range(0, TO - 1),
              $urandom, 1'($urandom_range(0, 1)));
    end

    check_val("exp_q_drained", DW'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
